// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SHOW,
    ST_FAULT
  } state_e;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to {g,f,e,d,c,b,a} segment pattern; non-decimal codes show a dash.
module bcd_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nib_i)
      4'd0: seg_o = 7'h3F;
      4'd1: seg_o = 7'h06;
      4'd2: seg_o = 7'h5B;
      4'd3: seg_o = 7'h4F;
      4'd4: seg_o = 7'h66;
      4'd5: seg_o = 7'h6D;
      4'd6: seg_o = 7'h7D;
      4'd7: seg_o = 7'h07;
      4'd8: seg_o = 7'h7F;
      4'd9: seg_o = 7'h6F;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver: dead-time blanking on each
// phase change, frame swap on the 1000->0001 wrap, sticky non-one-hot fault flag.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  phase,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  input  logic        clr_err,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        phase_err
);

  localparam logic [4:0] BLANK_N = 5'(BLANK_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  phase_q, phase_d;
  logic [15:0] active_q, active_d;
  logic [15:0] pend_q, pend_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        legal, load_ph, swap, accept, show;
  logic [3:0]  sel_nib;
  logic [6:0]  dec_seg;

  always_comb begin
    legal    = is_onehot4(phase);
    load_ph  = legal && ((state_q == ST_FAULT) || (phase != phase_q));
    swap     = load_ph && (phase_q == 4'b1000) && (phase == 4'b0001) && !rdy_q;
    accept   = ld_valid && rdy_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    active_d = active_q;
    pend_d   = pend_q;
    rdy_d    = rdy_q;
    err_d    = clr_err ? 1'b0 : err_q;

    if (!legal) begin
      state_d = ST_FAULT;
      err_d   = 1'b1;
    end else if (load_ph) begin
      phase_d = phase;
      cnt_d   = '0;
      state_d = (BLANK_N == 5'd0) ? ST_SHOW : ST_BLANK;
    end else if (state_q == ST_BLANK) begin
      // The cycle in which the count reaches BLANK_CYCLES is already lit.
      if (({1'b0, cnt_q} + 5'd1) >= BLANK_N) state_d = ST_SHOW;
      else                                   cnt_d   = cnt_q + 4'd1;
    end

    if (swap) begin
      active_d = pend_q;
      rdy_d    = 1'b1;
    end
    if (accept) begin
      pend_d = ld_data;
      rdy_d  = 1'b0;
    end

    show = (state_d == ST_SHOW) && (phase_d != 4'b0000);
    an_d = show ? phase_d : 4'b0000;
  end

  // Outputs are registered from next-state values so blanking starts one edge after the change.
  always_comb begin
    sel_nib = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (phase_d[i]) sel_nib = sel_nib | active_d[4*i +: 4];
    end
  end

  bcd_to_seg u_dec (
    .nib_i (sel_nib),
    .seg_o (dec_seg)
  );

  assign seg_d = show ? dec_seg : SEG_OFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      phase_q  <= '0;
      active_q <= '0;
      pend_q   <= '0;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
      an_q     <= '0;
      seg_q    <= SEG_OFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign ld_ready  = rdy_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign phase_err = err_q;

endmodule
